// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered-latency ALU between two requesters.
// One operation in flight; result returned tagged with the issuing requester id.
module alu_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SEL_W   = 3,
   parameter int unsigned ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_rs1,
   input  logic [WIDTH-1:0] req0_rs2,
   input  logic [SEL_W-1:0] req0_sel,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_rs1,
   input  logic [WIDTH-1:0] req1_rs2,
   input  logic [SEL_W-1:0] req1_sel,
   output logic [WIDTH-1:0] alu_rs1,
   output logic [WIDTH-1:0] alu_rs2,
   output logic [SEL_W-1:0] alu_sel,
   input  logic [WIDTH-1:0] alu_sal,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [WIDTH-1:0] rs1;
      logic [WIDTH-1:0] rs2;
      logic [SEL_W-1:0] sel;
   } op_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             last;
   logic             grant_valid;
   logic             grant_id;
   logic             accept;
   logic             cnt_done;
   op_t              op0;
   op_t              op1;
   op_t              grant_op;

   assign op0      = '{rs1: req0_rs1, rs2: req0_rs2, sel: req0_sel};
   assign op1      = '{rs1: req1_rs1, rs2: req1_rs2, sel: req1_sel};
   assign cnt_done = (cnt == '0);

   // State register; busy is registered from the next state so it tracks state exactly
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept)    state_nxt = EXEC;
         EXEC:    if (cnt_done)  state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Round-robin grant: on a tie the requester that did not win last time goes
   always_comb begin
      grant_valid = req0_valid | req1_valid;
      grant_id    = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_id = ~last;
      end else if (req1_valid) begin
         grant_id = 1'b1;
      end
      grant_op   = grant_id ? op1 : op0;
      accept     = (state == IDLE) && grant_valid;
      req0_ready = accept && !grant_id;
      req1_ready = accept &&  grant_id;
   end

   // Operand, countdown and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_rs1   <= '0;
         alu_rs2   <= '0;
         alu_sel   <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         cnt       <= '0;
         last      <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  alu_rs1 <= grant_op.rs1;
                  alu_rs2 <= grant_op.rs2;
                  alu_sel <= grant_op.sel;
                  rsp_id  <= grant_id;
                  last    <= grant_id;
                  cnt     <= CNT_W'(ALU_LAT);
               end
            end
            EXEC: begin
               if (cnt_done) begin
                  rsp_data  <= alu_sal;
                  rsp_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (ALU_LAT=1 and 3) with stub ALUs,
// directed steps followed by random traffic against a transaction-level model.
module tb_alu_arbiter;
   localparam int unsigned W  = 32;
   localparam int unsigned SW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   bit mon_en = 1'b0;

   logic          rst        [2];
   logic          req0_valid [2];
   logic          req0_ready [2];
   logic          req1_valid [2];
   logic          req1_ready [2];
   logic [W-1:0]  req0_rs1   [2];
   logic [W-1:0]  req0_rs2   [2];
   logic [W-1:0]  req1_rs1   [2];
   logic [W-1:0]  req1_rs2   [2];
   logic [SW-1:0] req0_sel   [2];
   logic [SW-1:0] req1_sel   [2];
   logic [W-1:0]  alu_rs1    [2];
   logic [W-1:0]  alu_rs2    [2];
   logic [SW-1:0] alu_sel    [2];
   logic [W-1:0]  alu_sal    [2];
   logic          rsp_valid  [2];
   logic          rsp_ready  [2];
   logic          rsp_id     [2];
   logic [W-1:0]  rsp_data   [2];
   logic          busy       [2];

   logic [W:0]    q0 [$];
   bit            acc [2][2];

   function automatic logic [W-1:0] alu_fn(input logic [SW-1:0] s, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      case (s)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a << b[4:0];
         3'd6:    return a >> b[4:0];
         default: return W'($signed(a) < $signed(b));
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int unsigned LAT = (g == 0) ? 1 : 3;
      logic [W-1:0] pipe [LAT];

      // Stub ALU: LAT-stage pipeline of alu_fn on the registered operands
      always @(posedge clk) begin
         pipe[0] <= alu_fn(alu_sel[g], alu_rs1[g], alu_rs2[g]);
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign alu_sal[g] = pipe[LAT-1];

      alu_arbiter #(.WIDTH(W), .SEL_W(SW), .ALU_LAT(LAT)) u_dut (
         .clk(clk), .rst(rst[g]),
         .req0_valid(req0_valid[g]), .req0_ready(req0_ready[g]),
         .req0_rs1(req0_rs1[g]), .req0_rs2(req0_rs2[g]), .req0_sel(req0_sel[g]),
         .req1_valid(req1_valid[g]), .req1_ready(req1_ready[g]),
         .req1_rs1(req1_rs1[g]), .req1_rs2(req1_rs2[g]), .req1_sel(req1_sel[g]),
         .alu_rs1(alu_rs1[g]), .alu_rs2(alu_rs2[g]), .alu_sel(alu_sel[g]),
         .alu_sal(alu_sal[g]),
         .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
         .rsp_id(rsp_id[g]), .rsp_data(rsp_data[g]), .busy(busy[g])
      );

      // Transaction model: 0 = free, 1 = waiting on the ALU, 2 = result offered
      int            st = 0;
      int            wt = 0;
      bit            last = 1'b1;
      bit            e_id;
      logic [W-1:0]  e_rs1, e_rs2, e_data;
      logic [SW-1:0] e_sel;

      always @(posedge clk) begin
         bit gnt;
         if (mon_en) begin
            chk("busy", 32'(busy[g]), 32'(st != 0));
            if (rst[g]) begin
               st   = 0;
               last = 1'b1;
            end else begin
               case (st)
                  0: if (req0_valid[g] || req1_valid[g]) begin
                     gnt = (req0_valid[g] && req1_valid[g]) ? !last : req1_valid[g];
                     chk("ready0", 32'(req0_ready[g]), 32'(!gnt));
                     chk("ready1", 32'(req1_ready[g]), 32'(gnt));
                     e_id   = gnt;
                     e_rs1  = gnt ? req1_rs1[g] : req0_rs1[g];
                     e_rs2  = gnt ? req1_rs2[g] : req0_rs2[g];
                     e_sel  = gnt ? req1_sel[g] : req0_sel[g];
                     e_data = alu_fn(e_sel, e_rs1, e_rs2);
                     last   = gnt;
                     wt     = LAT + 1;
                     st     = 1;
                  end
                  1: begin
                     chk("exec_valid", 32'(rsp_valid[g]), 32'(0));
                     chk("exec_rs1", alu_rs1[g], e_rs1);
                     chk("exec_rs2", alu_rs2[g], e_rs2);
                     chk("exec_sel", 32'(alu_sel[g]), 32'(e_sel));
                     wt--;
                     if (wt == 0) st = 2;
                  end
                  default: begin
                     chk("rsp_valid", 32'(rsp_valid[g]), 32'(1));
                     chk("rsp_id", 32'(rsp_id[g]), 32'(e_id));
                     chk("rsp_data", rsp_data[g], e_data);
                     chk("resp_rs1", alu_rs1[g], e_rs1);
                     if (rsp_ready[g]) begin
                        st = 0;
                        if (g == 0) q0.push_back({e_id, e_data});
                     end
                  end
               endcase
            end
         end
      end
   end

   task automatic issue(input int d, input bit who, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [SW-1:0] s);
      if (who) begin
         req1_valid[d] = 1'b1; req1_rs1[d] = a; req1_rs2[d] = b; req1_sel[d] = s;
      end else begin
         req0_valid[d] = 1'b1; req0_rs1[d] = a; req0_rs2[d] = b; req0_sel[d] = s;
      end
      for (int i = 0; i < 50; i++) begin
         #2;
         if ((who ? req1_ready[d] : req0_ready[d]) === 1'b1) break;
         @(negedge clk);
      end
      chk("issue_ready", 32'(who ? req1_ready[d] : req0_ready[d]), 32'(1));
      @(negedge clk);
      if (who) req1_valid[d] = 1'b0; else req0_valid[d] = 1'b0;
   endtask

   task automatic wait_rsp(input int d);
      for (int i = 0; i < 100; i++) begin
         if (rsp_valid[d] === 1'b1) break;
         @(negedge clk);
      end
      chk("wait_rsp", 32'(rsp_valid[d]), 32'(1));
   endtask

   task automatic drain(input int d);
      rsp_ready[d] = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (busy[d] === 1'b0) break;
         @(negedge clk);
      end
      chk("drain_busy", 32'(busy[d]), 32'(0));
   endtask

   task automatic reset_chk(input int d);
      chk("rst_alu_rs1", alu_rs1[d], 32'(0));
      chk("rst_alu_rs2", alu_rs2[d], 32'(0));
      chk("rst_alu_sel", 32'(alu_sel[d]), 32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'(0));
      chk("rst_rsp_id", 32'(rsp_id[d]), 32'(0));
      chk("rst_rsp_data", rsp_data[d], 32'(0));
      chk("rst_busy", 32'(busy[d]), 32'(0));
   endtask

   initial begin
      int n;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; rsp_ready[d] = 1'b0;
         req0_valid[d] = 1'b0; req0_rs1[d] = '0; req0_rs2[d] = '0; req0_sel[d] = '0;
         req1_valid[d] = 1'b0; req1_rs1[d] = '0; req1_rs2[d] = '0; req1_sel[d] = '0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) reset_chk(d);
      mon_en = 1'b1;
      rst[1] = 1'b0;

      // Single op 226+7 on the latency-1 instance
      rst[0] = 1'b0;
      issue(0, 1'b0, 226, 7, 3'd0);
      chk("t1_alu_rs1", alu_rs1[0], 226);
      chk("t1_alu_rs2", alu_rs2[0], 7);
      chk("t1_busy", 32'(busy[0]), 32'(1));
      @(negedge clk);
      chk("t1_early", 32'(rsp_valid[0]), 32'(0));
      @(negedge clk);
      chk("t1_valid", 32'(rsp_valid[0]), 32'(1));
      chk("t1_data", rsp_data[0], 233);
      chk("t1_id", 32'(rsp_id[0]), 32'(0));
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      chk("t1_done_valid", 32'(rsp_valid[0]), 32'(0));
      chk("t1_done_busy", 32'(busy[0]), 32'(0));
      chk("t1_retain", alu_rs1[0], 226);

      // Contention: both valid from reset release
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      q0.delete();
      req0_valid[0] = 1'b1; req0_rs1[0] = 1; req0_rs2[0] = 2; req0_sel[0] = 3'd0;
      req1_valid[0] = 1'b1; req1_rs1[0] = 3; req1_rs2[0] = 4; req1_sel[0] = 3'd1;
      for (int i = 0; i < 100 && q0.size() < 4; i++) @(negedge clk);
      req0_valid[0] = 1'b0; req1_valid[0] = 1'b0;
      chk("t2_count", 32'(q0.size() >= 4), 32'(1));
      for (int i = 0; i < 4 && i < q0.size(); i++) chk("t2_order", 32'(q0[i][W]), 32'(i % 2));
      drain(0);

      // Backpressure: response held while req1 waits
      rsp_ready[0] = 1'b0;
      issue(0, 1'b0, 'h55, 'h11, 3'd1);
      wait_rsp(0);
      req1_valid[0] = 1'b1; req1_rs1[0] = 9; req1_rs2[0] = 9; req1_sel[0] = 3'd2;
      for (int i = 0; i < 5; i++) begin
         chk("t3_valid", 32'(rsp_valid[0]), 32'(1));
         chk("t3_data", rsp_data[0], 'h44);
         chk("t3_id", 32'(rsp_id[0]), 32'(0));
         chk("t3_ready1", 32'(req1_ready[0]), 32'(0));
         @(negedge clk);
      end
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      chk("t3_idle", 32'(busy[0]), 32'(0));
      chk("t3_ready1_now", 32'(req1_ready[0]), 32'(1));
      @(negedge clk);
      req1_valid[0] = 1'b0;
      chk("t3_accepted", 32'(busy[0]), 32'(1));
      chk("t3_alu_rs1", alu_rs1[0], 9);
      chk("t3_alu_sel", 32'(alu_sel[0]), 32'(2));
      drain(0);

      // Latency 3: result appears exactly four edges after accept
      rsp_ready[1] = 1'b1;
      issue(1, 1'b1, 10, 5, 3'd0);
      for (int i = 0; i < 4; i++) begin
         chk("t4_early", 32'(rsp_valid[1]), 32'(0));
         @(negedge clk);
      end
      chk("t4_valid", 32'(rsp_valid[1]), 32'(1));
      chk("t4_data", rsp_data[1], 15);
      chk("t4_id", 32'(rsp_id[1]), 32'(1));
      drain(1);

      // Reset one cycle after accept drops the op; held req0 is re-accepted
      n = q0.size();
      rsp_ready[0] = 1'b1;
      req0_valid[0] = 1'b1; req0_rs1[0] = 100; req0_rs2[0] = 1; req0_sel[0] = 3'd0;
      #2;
      chk("t5_ready0", 32'(req0_ready[0]), 32'(1));
      @(negedge clk);
      chk("t5_busy", 32'(busy[0]), 32'(1));
      rst[0] = 1'b1;
      @(negedge clk);
      reset_chk(0);
      rst[0] = 1'b0;
      @(negedge clk);
      req0_valid[0] = 1'b0;
      chk("t5_reaccept", 32'(busy[0]), 32'(1));
      chk("t5_alu_rs1", alu_rs1[0], 100);
      drain(0);
      chk("t5_one_rsp", 32'(q0.size()), 32'(n + 1));
      if (q0.size() > 0) chk("t5_data", q0[$][W-1:0], 101);

      // Op sweep on requester 1
      q0.delete();
      for (int s = 0; s < 8; s++) begin
         issue(0, 1'b1, 226, 7, SW'(s));
         chk("t6_alu_sel", 32'(alu_sel[0]), 32'(s));
      end
      drain(0);
      chk("t6_count", 32'(q0.size()), 32'(8));
      for (int i = 0; i < 8 && i < q0.size(); i++) begin
         chk("t6_id", 32'(q0[i][W]), 32'(1));
         chk("t6_data", q0[i][W-1:0], alu_fn(SW'(i), 226, 7));
      end

      // Random traffic on both instances; requesters hold until handshake
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (acc[d][0]) begin req0_valid[d] = 1'b0; acc[d][0] = 1'b0; end
            if (acc[d][1]) begin req1_valid[d] = 1'b0; acc[d][1] = 1'b0; end
            if (!req0_valid[d] && $urandom_range(0, 2) == 0) begin
               req0_valid[d] = 1'b1; req0_rs1[d] = $urandom; req0_rs2[d] = $urandom;
               req0_sel[d] = SW'($urandom_range(0, 7));
            end
            if (!req1_valid[d] && $urandom_range(0, 2) == 0) begin
               req1_valid[d] = 1'b1; req1_rs1[d] = $urandom; req1_rs2[d] = $urandom;
               req1_sel[d] = SW'($urandom_range(0, 7));
            end
            rsp_ready[d] = ($urandom_range(0, 3) != 0);
         end
         #2;
         for (int d = 0; d < 2; d++) begin
            if (req0_valid[d] && req0_ready[d]) acc[d][0] = 1'b1;
            if (req1_valid[d] && req1_ready[d]) acc[d][1] = 1'b1;
         end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         req0_valid[d] = 1'b0;
         req1_valid[d] = 1'b0;
      end
      drain(0);
      drain(1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single clocked ALU (operands rs1/rs2, 3-bit op select sel, registered result sal) between two requesters, e.g. the execute stage and a debug/test port.
- Round-robin arbitration with valid/ready request handshake.
- Drives and holds ALU operands for the ALU's registered latency, then returns the result tagged with the requester id via a valid/ready response handshake.
- One operation in flight at a time.

Parameters:
- WIDTH, 32, operand/result width.
- SEL_W, 3, ALU op-select width.
- ALU_LAT, 1, clock edges from operands registered into the ALU to sal valid. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_rs1  input  WIDTH  requester 0 operand 1
- req0_rs2  input  WIDTH  requester 0 operand 2
- req0_sel  input  SEL_W  requester 0 op select
- req1_valid, req1_ready, req1_rs1, req1_rs2, req1_sel  same as requester 0, for requester 1
- alu_rs1  output  WIDTH  registered operand 1 to ALU
- alu_rs2  output  WIDTH  registered operand 2 to ALU
- alu_sel  output  SEL_W  registered op select to ALU
- alu_sal  input  WIDTH  ALU result
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_id  output  1  requester that issued the result
- rsp_data  output  WIDTH  result value
- busy  output  1  high whenever state is not IDLE

Behaviour:
- States: IDLE, EXEC, RESP.
- Reset (rst high at a posedge):
  - state=IDLE; alu_rs1/rs2/sel=0; rsp_valid=0; rsp_id=0; rsp_data=0; cnt=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - Reset overrides every other event. An operation in EXEC or RESP is dropped and never responded to.
- Arbitration (combinational, IDLE only):
  - One valid requester: it is granted.
  - Both valid: the requester other than last is granted.
  - reqN_ready = (state==IDLE) && grant==N. At most one ready is high; both ready are 0 outside IDLE.
- IDLE:
  - On a posedge with granted valid&ready: register the granted rs1/rs2/sel into alu_*, rsp_id=granted id, last=granted id, cnt=ALU_LAT; go to EXEC.
  - No valid: stay in IDLE, nothing changes.
- EXEC:
  - alu_* held stable.
  - Each posedge: if cnt==0, rsp_data<=alu_sal, rsp_valid<=1, go to RESP; else cnt<=cnt-1.
  - Timing: with handshake at edge E0, rsp_data is captured at edge E0+ALU_LAT+1 and rsp_valid is high after that edge.
- RESP:
  - rsp_valid, rsp_id and rsp_data held stable until rsp_ready.
  - Posedge with rsp_ready=1: rsp_valid<=0, go to IDLE.
  - No new request is accepted in the same cycle, so minimum spacing is ALU_LAT+3 cycles per op.
- alu_* retain the last operation after completion; they are changed only by the next accept or by reset.
- Requesters must hold valid and operands until ready. A valid that drops before handshake has no effect, and nothing is latched before the handshake.
- Width rules:
  - rsp_data is the unmodified alu_sal; no arithmetic is performed in this block.
  - cnt is 4 bits wide.

Test Plan:
- Single op (stub ALU registering rs1+rs2, ALU_LAT=1): req0 rs1=226, rs2=7, sel=0, handshake at E0 -> alu_rs1=226 after E0; rsp_valid=1, rsp_data=233, rsp_id=0 after E2; busy high from E0 to the response handshake.
- Contention: both valid continuously from reset release with rsp_ready=1 -> grant order 0,1,0,1; rsp_id alternates; exactly one ready high per accept.
- Backpressure: rsp_ready=0 for 5 cycles while req1_valid=1 -> rsp_valid/rsp_data/rsp_id stable; req1_ready stays 0; accepted on the cycle after rsp_ready=1.
- Latency param: ALU_LAT=3, req1 rs1=10, rs2=5 -> rsp_data=15 captured at E0+4; nothing earlier.
- Reset mid-EXEC: assert rst one cycle after accept -> next cycle all outputs 0, no rsp_valid ever for that op; a still-valid req0 is re-accepted in the first IDLE cycle after rst falls.
- Op sweep: req1 issues sel=0..7 back-to-back with rs1=226, rs2=7 -> alu_sel matches each sel; 8 responses in order, each rsp_data equal to the stub ALU's output for that sel.
